// File: rtl/nphy_toggle_pkg.sv
// rtl/nphy_toggle_pkg.sv - shared state type, packing function and defaults for the DQS burst capture
package nphy_toggle_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    CAPTURE  = 2'd2,
    DONE     = 2'd3
  } burstState_t;

  localparam int DEFAULT_PREAMBLE_CYCLES = 2;

  // FIFO word layout: each byte has its nibbles swapped, rising byte in the upper half
  function automatic logic [15:0] packWord(input logic [7:0] rise, input logic [7:0] fall);
    return {rise[3:0], rise[7:4], fall[3:0], fall[7:4]};
  endfunction

endpackage

// File: rtl/nphy_cdc_sync_bit.sv
// rtl/nphy_cdc_sync_bit.sv - multi-flop level synchronizer into the DQS clock domain
module nphy_cdc_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic wDelayedDQSClock,
  input  logic rBufferReset,
  input  logic iAsync,
  output logic oSync
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] rSync;

  // Shift the asynchronous level through the chain; the last stage is the safe copy
  always_ff @(posedge wDelayedDQSClock or posedge rBufferReset) begin
    if (rBufferReset) rSync <= '0;
    else              rSync <= (rSync << 1) | SYNC_STAGES'(iAsync);
  end

  assign oSync = rSync[SYNC_STAGES-1];

endmodule

// File: rtl/nphy_toggle_dqs_burst_capture.sv
// rtl/nphy_toggle_dqs_burst_capture.sv - DQS-domain burst writer into the input FIFO; NPHY_BURST_CHECKSUM_EN adds oChecksum
module nphy_toggle_dqs_burst_capture
  import nphy_toggle_pkg::*;
#(
  parameter int PREAMBLE_CYCLES = DEFAULT_PREAMBLE_CYCLES,
  parameter int WORD_CNT_W      = 12,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                  wDelayedDQSClock,
  input  logic                  rBufferReset,
  input  logic                  iArm,
  input  logic [WORD_CNT_W-1:0] iBurstWords,
  input  logic [7:0]            iDQAtRising,
  input  logic [7:0]            iDQAtFalling,
  input  logic                  iFifoFull,
  output logic [15:0]           oFifoDin,
  output logic                  oFifoWrEn,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oOverflow,
  output logic                  oAborted,
  output logic [WORD_CNT_W-1:0] oWordCount
`ifdef NPHY_BURST_CHECKSUM_EN
  ,
  output logic [15:0]           oChecksum
`endif
);

  localparam int PRE_CNT_W = (PREAMBLE_CYCLES > 1) ? $clog2(PREAMBLE_CYCLES) : 1;
  localparam logic [PRE_CNT_W-1:0] PRE_LAST =
    (PREAMBLE_CYCLES > 0) ? PRE_CNT_W'(PREAMBLE_CYCLES - 1) : '0;

  burstState_t           rState;
  logic [PRE_CNT_W-1:0]  rPreCnt;
  logic                  sArm;
  logic                  rArmQ;
  logic [15:0]           rCapWord;
  logic                  rCapValid;
  logic                  rCapConsumed;
  logic                  wArmRise;
  logic                  wBurstEmpty;
  logic [WORD_CNT_W-1:0] wNextCount;

  nphy_cdc_sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) uArmSync (
    .wDelayedDQSClock(wDelayedDQSClock),
    .rBufferReset    (rBufferReset),
    .iAsync          (iArm),
    .oSync           (sArm)
  );

  assign wArmRise    = sArm & ~rArmQ;
  assign wBurstEmpty = (iBurstWords == '0);
  assign wNextCount  = oWordCount + WORD_CNT_W'(1);

  // Burst FSM: arm edge detect, preamble skip, per-edge pair capture and status flags
  always_ff @(posedge wDelayedDQSClock or posedge rBufferReset) begin
    if (rBufferReset) begin
      rState       <= IDLE;
      rPreCnt      <= '0;
      rArmQ        <= 1'b0;
      rCapWord     <= '0;
      rCapValid    <= 1'b0;
      rCapConsumed <= 1'b0;
      oBusy        <= 1'b0;
      oDone        <= 1'b0;
      oOverflow    <= 1'b0;
      oAborted     <= 1'b0;
      oWordCount   <= '0;
    end else begin
      rArmQ        <= sArm;
      rCapValid    <= 1'b0;
      rCapConsumed <= 1'b0;
      case (rState)
        IDLE: begin
          if (wArmRise) begin
            oWordCount <= '0;
            oOverflow  <= 1'b0;
            oAborted   <= 1'b0;
            rPreCnt    <= '0;
            if (PREAMBLE_CYCLES != 0) begin
              rState <= PREAMBLE;
              oBusy  <= 1'b1;
            end else if (wBurstEmpty) begin
              rState <= DONE;
              oDone  <= 1'b1;
            end else begin
              rState <= CAPTURE;
              oBusy  <= 1'b1;
            end
          end
        end
        PREAMBLE: begin
          if (!sArm) begin
            rState   <= IDLE;
            oBusy    <= 1'b0;
            oAborted <= 1'b1;
          end else if (rPreCnt == PRE_LAST) begin
            if (wBurstEmpty) begin
              rState <= DONE;
              oBusy  <= 1'b0;
              oDone  <= 1'b1;
            end else begin
              rState <= CAPTURE;
            end
          end else begin
            rPreCnt <= rPreCnt + 1'b1;
          end
        end
        CAPTURE: begin
          if (!sArm) begin
            rState   <= IDLE;
            oBusy    <= 1'b0;
            oAborted <= 1'b1;
          end else begin
            // A full FIFO drops the word but still consumes a slot so the burst length holds
            rCapWord     <= packWord(iDQAtRising, iDQAtFalling);
            rCapConsumed <= 1'b1;
            rCapValid    <= ~iFifoFull;
            if (iFifoFull) oOverflow <= 1'b1;
            oWordCount <= wNextCount;
            if (wNextCount == iBurstWords) begin
              rState <= DONE;
              oBusy  <= 1'b0;
              oDone  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!sArm) begin
            rState <= IDLE;
            oDone  <= 1'b0;
          end
        end
        default: begin
          rState <= IDLE;
          oBusy  <= 1'b0;
          oDone  <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: one cycle behind capture, so a word captured just before an abort still strobes
  always_ff @(posedge wDelayedDQSClock or posedge rBufferReset) begin
    if (rBufferReset) begin
      oFifoDin  <= '0;
      oFifoWrEn <= 1'b0;
    end else begin
      oFifoWrEn <= rCapValid;
      if (rCapValid) oFifoDin <= rCapWord;
    end
  end

`ifdef NPHY_BURST_CHECKSUM_EN
  // Running XOR of every consumed word, written or dropped, aligned with the write strobe
  always_ff @(posedge wDelayedDQSClock or posedge rBufferReset) begin
    if (rBufferReset)                     oChecksum <= '0;
    else if (rState == IDLE && wArmRise)  oChecksum <= '0;
    else if (rCapConsumed)                oChecksum <= oChecksum ^ rCapWord;
  end
`endif

endmodule
